// File: rtl/rlo_writeback_pkg.sv
// Shared definitions for the RLO write-back block: opcode and destination
// encodings, FSM state encoding, and the per-bit result rule.
package rlo_wb_pkg;

  typedef enum logic [1:0] {
    OP_ASSIGN = 2'b00,
    OP_SET    = 2'b01,
    OP_RESET  = 2'b10,
    OP_NOP    = 2'b11
  } op_t;

  localparam logic DEST_RAM = 1'b0;
  localparam logic DEST_REG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_MOD  = 2'b10,
    ST_WR   = 2'b11
  } state_t;

  // A command touches storage only when it can change a bit:
  // assign always, set/reset only when RLO is 1, nop never.
  function automatic logic op_effective(input op_t op, input logic rlo);
    return (op == OP_ASSIGN) || (((op == OP_SET) || (op == OP_RESET)) && rlo);
  endfunction

  // New value of the addressed bit given its old value.
  function automatic logic op_result(input op_t op, input logic rlo, input logic old_bit);
    logic r;
    case (op)
      OP_ASSIGN: r = rlo;
      OP_SET:    r = rlo ? 1'b1 : old_bit;
      OP_RESET:  r = rlo ? 1'b0 : old_bit;
      default:   r = old_bit;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rlo_writeback_if.sv
// Command interface of the RLO write-back block.
// Handshake: a command transfers on the rising clock edge where WB_Valid and
// WB_Ready are both high; the master holds all command fields stable while
// WB_Valid is high and not yet accepted. WB_Done is a one-cycle completion
// pulse from the slave and needs no acknowledge.
interface rlo_writeback_if
  import rlo_wb_pkg::*;
#(
  parameter int ADDR_W = 13
);
  logic              WB_Valid;
  logic              WB_Ready;
  op_t               WB_OPCode;
  logic              WB_Dest;
  logic [ADDR_W-1:0] WB_Addr;
  logic              WB_RLO;
  logic              WB_Done;

  modport master (
    output WB_Valid, WB_OPCode, WB_Dest, WB_Addr, WB_RLO,
    input  WB_Ready, WB_Done
  );

  modport slave (
    input  WB_Valid, WB_OPCode, WB_Dest, WB_Addr, WB_RLO,
    output WB_Ready, WB_Done
  );
endinterface

// File: rtl/rlo_wb_bitmerge.sv
// Combinational single-bit merge: returns the word with only bit[idx]
// replaced by the opcode's result. Used for both the RAM byte and the
// register file.
module rlo_wb_bitmerge
  import rlo_wb_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_word,
  input  logic [IW-1:0] i_idx,
  input  op_t           i_op,
  input  logic          i_rlo,
  output logic [W-1:0]  o_word
);

  // Copy the word, then overwrite only the addressed bit.
  always_comb begin
    o_word         = i_word;
    o_word[i_idx]  = op_result(i_op, i_rlo, i_word[i_idx]);
  end

endmodule

// File: rtl/rlo_writeback.sv
// RLO write-back: commits one bit-write command either to byte-wide data RAM
// (read-modify-write, 4-cycle throughput) or to the internal bit register file.
// Optional feature macro: RLO_WB_FWD_EN adds a forwarding port that exposes
// the bit being written while a RAM read-modify-write is in flight.
module rlo_writeback
  import rlo_wb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int REG_N  = 8
) (
  input  logic                CLK,
  input  logic                RST_n,
  rlo_writeback_if.slave      wb,
  output logic [ADDR_W-4:0]   RAM_Addr,
  output logic                RAM_RdEn,
  input  logic [DATA_W-1:0]   RAM_RdData,
  output logic                RAM_WrEn,
  output logic [DATA_W-1:0]   RAM_WrData,
  output logic [REG_N-1:0]    WB_Register,
`ifdef RLO_WB_FWD_EN
  output logic                WB_FwdValid,
  output logic [ADDR_W-1:0]   WB_FwdAddr,
  output logic                WB_FwdBit,
`endif
  output state_t              o_dbg_state
);

  localparam int BYTE_W = ADDR_W - 3;
  localparam int REG_IW = $clog2(REG_N);

  state_t              r_state;
  logic                r_ready;
  logic                r_done;
  logic                r_rd_en;
  logic                r_wr_en;
  logic [BYTE_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [REG_N-1:0]    r_reg;
  op_t                 r_op;
  logic                r_rlo;
  logic [2:0]          r_idx;
`ifdef RLO_WB_FWD_EN
  logic                r_fwd_valid;
  logic [ADDR_W-1:0]   r_fwd_addr;
  logic                r_fwd_bit;
`endif

  logic                w_accept;
  logic                w_eff;
  logic                w_ram_cmd;
  logic                w_reg_cmd;
  logic [DATA_W-1:0]   w_ram_merged;
  logic [REG_N-1:0]    w_reg_merged;

  // Ready is only ever high in IDLE, so accept implies IDLE.
  assign w_accept  = wb.WB_Valid & r_ready;
  assign w_eff     = op_effective(wb.WB_OPCode, wb.WB_RLO);
  assign w_ram_cmd = w_eff & (wb.WB_Dest == DEST_RAM);
  assign w_reg_cmd = w_eff & (wb.WB_Dest == DEST_REG);

  // RAM path merges the read byte with the latched command fields.
  rlo_wb_bitmerge #(.W(DATA_W)) u_ram_merge (
    .i_word (RAM_RdData),
    .i_idx  (r_idx),
    .i_op   (r_op),
    .i_rlo  (r_rlo),
    .o_word (w_ram_merged)
  );

  // Register path merges at acceptance using the live command fields.
  rlo_wb_bitmerge #(.W(REG_N)) u_reg_merge (
    .i_word (r_reg),
    .i_idx  (wb.WB_Addr[REG_IW-1:0]),
    .i_op   (wb.WB_OPCode),
    .i_rlo  (wb.WB_RLO),
    .o_word (w_reg_merged)
  );

  // Control FSM with all outputs registered; RAM commands walk RD -> MOD -> WR.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_ram_addr <= '0;
      r_wr_data  <= '0;
      r_reg      <= '0;
      r_op       <= OP_NOP;
      r_rlo      <= 1'b0;
      r_idx      <= '0;
`ifdef RLO_WB_FWD_EN
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_bit   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            if (w_ram_cmd) begin
              r_state    <= ST_RD;
              r_ready    <= 1'b0;
              r_rd_en    <= 1'b1;
              r_ram_addr <= wb.WB_Addr[ADDR_W-1:3];
              r_op       <= wb.WB_OPCode;
              r_rlo      <= wb.WB_RLO;
              r_idx      <= wb.WB_Addr[2:0];
`ifdef RLO_WB_FWD_EN
              r_fwd_valid <= 1'b1;
              r_fwd_addr  <= wb.WB_Addr;
              // Effective set/reset already fix the bit; assign carries RLO.
              r_fwd_bit   <= op_result(wb.WB_OPCode, wb.WB_RLO, 1'b0);
`endif
            end else begin
              // Register writes and no-ops complete in place.
              r_done <= 1'b1;
              if (w_reg_cmd) begin
                r_reg <= w_reg_merged;
              end
            end
          end
        end
        ST_RD: begin
          r_rd_en <= 1'b0;
          r_state <= ST_MOD;
        end
        ST_MOD: begin
          r_wr_data <= w_ram_merged;
          r_wr_en   <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= ST_WR;
        end
        ST_WR: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
`ifdef RLO_WB_FWD_EN
          r_fwd_valid <= 1'b0;
          r_fwd_addr  <= '0;
          r_fwd_bit   <= 1'b0;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign wb.WB_Ready = r_ready;
  assign wb.WB_Done  = r_done;
  assign RAM_Addr    = r_ram_addr;
  assign RAM_RdEn    = r_rd_en;
  assign RAM_WrEn    = r_wr_en;
  assign RAM_WrData  = r_wr_data;
  assign WB_Register = r_reg;
  assign o_dbg_state = r_state;
`ifdef RLO_WB_FWD_EN
  assign WB_FwdValid = r_fwd_valid;
  assign WB_FwdAddr  = r_fwd_addr;
  assign WB_FwdBit   = r_fwd_bit;
`endif

endmodule

// File: tb/tb_rlo_writeback.sv
// Bench for rlo_writeback: directed scenarios plus randomized commands,
// checked against a bit-level memory/register model.
module tb_rlo_writeback;
  import rlo_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST_n;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT ----------------
  rlo_writeback_if #(.ADDR_W(13)) wb_if ();
  logic [9:0] RAM_Addr;
  logic       RAM_RdEn;
  logic [7:0] ram_rdata;
  logic       RAM_WrEn;
  logic [7:0] RAM_WrData;
  logic [7:0] WB_Register;
  state_t     dbg_state;
`ifdef RLO_WB_FWD_EN
  logic        WB_FwdValid;
  logic [12:0] WB_FwdAddr;
  logic        WB_FwdBit;
`endif

  rlo_writeback #(.ADDR_W(13), .DATA_W(8), .REG_N(8)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .wb          (wb_if.slave),
    .RAM_Addr    (RAM_Addr),
    .RAM_RdEn    (RAM_RdEn),
    .RAM_RdData  (ram_rdata),
    .RAM_WrEn    (RAM_WrEn),
    .RAM_WrData  (RAM_WrData),
    .WB_Register (WB_Register),
`ifdef RLO_WB_FWD_EN
    .WB_FwdValid (WB_FwdValid),
    .WB_FwdAddr  (WB_FwdAddr),
    .WB_FwdBit   (WB_FwdBit),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- RAM environment ----------------
  logic [7:0] mem [0:1023];
  logic       poke_en;
  logic [9:0] poke_addr;
  logic [7:0] poke_data;
  int         wr_cnt;
  int         both_cnt;

  always @(posedge CLK) begin
    if (RAM_RdEn) ram_rdata <= mem[RAM_Addr];
    if (RAM_WrEn) mem[RAM_Addr] <= RAM_WrData;
    else if (poke_en) mem[poke_addr] <= poke_data;
    if (RAM_WrEn) wr_cnt <= wr_cnt + 1;
    if (RAM_WrEn && RAM_RdEn) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_ram [0:1023];
  logic [7:0] exp_reg;
  logic [7:0] exp_q [$];
  int         exp_wr_cnt;
  int         n_checks;
  int         n_errors;

  // Per-cycle capture of one command's timeline (cycle 1 = T1).
  logic [3:0] tr_sig  [1:8];
  logic [9:0] tr_addr [1:8];
  logic [7:0] tr_wd   [1:8];
  logic [7:0] tr_reg  [1:8];
`ifdef RLO_WB_FWD_EN
  logic        tr_fv [1:8];
  logic [12:0] tr_fa [1:8];
  logic        tr_fb [1:8];
`endif

  // Apply one command to the model; RAM-bound effective commands push the
  // expected written byte onto exp_q.
  task automatic model_cmd(input logic [1:0] op, input logic dest, input logic [12:0] addr,
                           input logic rlo, output bit is_ram);
    bit         eff;
    logic       nb;
    int         b;
    logic [2:0] idx;
    eff    = (op == 2'd0) || (((op == 2'd1) || (op == 2'd2)) && rlo);
    is_ram = eff && !dest;
    if (!eff) return;
    nb  = (op == 2'd0) ? rlo : (op == 2'd1);
    idx = addr[2:0];
    if (dest) begin
      exp_reg = (exp_reg & ~(8'd1 << idx)) | ({7'd0, nb} << idx);
    end else begin
      b = int'(addr[12:3]);
      exp_ram[b] = (exp_ram[b] & ~(8'd1 << idx)) | ({7'd0, nb} << idx);
      exp_q.push_back(exp_ram[b]);
      exp_wr_cnt++;
    end
  endtask

  // Expected {RdEn, WrEn, Done, Ready} in cycle c after acceptance.
  function automatic logic [3:0] exp_sig(input bit is_ram, input int c);
    if (is_ram) return {c == 1, c == 3, c == 3, !((c >= 1) && (c <= 3))};
    return {1'b0, 1'b0, c == 1, 1'b1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic poke(input int a, input logic [7:0] d);
    poke_en   = 1'b1;
    poke_addr = 10'(a);
    poke_data = d;
    exp_ram[a] = d;
    @(posedge CLK);
    #1 poke_en = 1'b0;
  endtask

  task automatic capture(input int c);
    tr_sig[c]  = {RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready};
    tr_addr[c] = RAM_Addr;
    tr_wd[c]   = RAM_WrData;
    tr_reg[c]  = WB_Register;
`ifdef RLO_WB_FWD_EN
    tr_fv[c] = WB_FwdValid;
    tr_fa[c] = WB_FwdAddr;
    tr_fb[c] = WB_FwdBit;
`endif
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic dest, input logic [12:0] addr,
                           input logic rlo);
    wb_if.WB_OPCode = op_t'(op);
    wb_if.WB_Dest   = dest;
    wb_if.WB_Addr   = addr;
    wb_if.WB_RLO    = rlo;
  endtask

  task automatic issue_and_trace(input logic [1:0] op, input logic dest, input logic [12:0] addr,
                                 input logic rlo, input int ncyc);
    @(negedge CLK);
    drive_cmd(op, dest, addr, rlo);
    wb_if.WB_Valid = 1'b1;
    @(posedge CLK);
    #1 wb_if.WB_Valid = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      capture(c);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    n_checks++;
    if ({RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_strobes got %b exp 0001", {RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready});
    end
    n_checks++;
    if ({RAM_Addr, RAM_WrData, WB_Register} !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_data got addr %h wd %h reg %h exp 0", RAM_Addr, RAM_WrData, WB_Register);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    // Valid low while ready: nothing may happen.
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready} !== 4'b0001) begin
        n_errors++;
        $display("FAIL idle_quiet cyc %0d got %b exp 0001", c, {RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready});
      end
    end
  endtask

  task automatic test_assign_ram;
    bit         is_ram;
    logic [7:0] e;
    poke(32'h12, 8'h00);
    model_cmd(2'd0, 1'b0, 13'h93, 1'b1, is_ram);
    e = exp_q.pop_front();
    issue_and_trace(2'd0, 1'b0, 13'h93, 1'b1, 5);
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if (tr_sig[c] !== exp_sig(1'b1, c)) begin
        n_errors++;
        $display("FAIL assign_ram_sig cyc %0d got %b exp %b", c, tr_sig[c], exp_sig(1'b1, c));
      end
    end
    n_checks++;
    if (tr_wd[3] !== 8'h08 || e !== 8'h08) begin
      n_errors++;
      $display("FAIL assign_ram_wdata got %h model %h exp 08", tr_wd[3], e);
    end
    n_checks++;
    if (tr_addr[1] !== 10'h12 || tr_addr[3] !== 10'h12) begin
      n_errors++;
      $display("FAIL assign_ram_addr got %h/%h exp 012", tr_addr[1], tr_addr[3]);
    end
  endtask

  task automatic test_reset_op_ram;
    bit         is_ram;
    logic [7:0] e;
    poke(32'h12, 8'hFF);
    model_cmd(2'd2, 1'b0, 13'h97, 1'b1, is_ram);
    e = exp_q.pop_front();
    issue_and_trace(2'd2, 1'b0, 13'h97, 1'b1, 5);
    n_checks++;
    if (tr_wd[3] !== 8'h7F || e !== 8'h7F) begin
      n_errors++;
      $display("FAIL reset_op_wdata got %h model %h exp 7f", tr_wd[3], e);
    end
    n_checks++;
    if (tr_sig[3] !== 4'b0110) begin
      n_errors++;
      $display("FAIL reset_op_t3 got %b exp 0110", tr_sig[3]);
    end
  endtask

  task automatic test_noop;
    bit is_ram;
    model_cmd(2'd1, 1'b0, 13'h0A5, 1'b0, is_ram);
    issue_and_trace(2'd1, 1'b0, 13'h0A5, 1'b0, 4);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (tr_sig[c] !== exp_sig(1'b0, c)) begin
        n_errors++;
        $display("FAIL noop_sig cyc %0d got %b exp %b", c, tr_sig[c], exp_sig(1'b0, c));
      end
    end
  endtask

  task automatic test_reg_dest;
    bit is_ram;
    model_cmd(2'd0, 1'b1, 13'd5, 1'b1, is_ram);
    issue_and_trace(2'd0, 1'b1, 13'd5, 1'b1, 3);
    n_checks++;
    if (tr_reg[1] !== 8'h20 || exp_reg !== 8'h20) begin
      n_errors++;
      $display("FAIL reg_dest_value got %h model %h exp 20", tr_reg[1], exp_reg);
    end
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (tr_sig[c] !== exp_sig(1'b0, c)) begin
        n_errors++;
        $display("FAIL reg_dest_sig cyc %0d got %b exp %b", c, tr_sig[c], exp_sig(1'b0, c));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit          r1, r2;
    logic [12:0] a1, a2;
    logic        rlo1;
    logic [7:0]  e1, e2;
    a1   = 13'($urandom_range(0, 8191));
    a2   = 13'($urandom_range(0, 8191));
    rlo1 = 1'($urandom_range(0, 1));
    model_cmd(2'd0, 1'b0, a1, rlo1, r1);
    model_cmd(2'd1, 1'b0, a2, 1'b1, r2);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    @(negedge CLK);
    drive_cmd(2'd0, 1'b0, a1, rlo1);
    wb_if.WB_Valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      capture(c);
      // Second command's fields appear while busy; they must wait for IDLE.
      if (c == 1) drive_cmd(2'd1, 1'b0, a2, 1'b1);
      if (c == 4) begin
        @(posedge CLK);
        #1 wb_if.WB_Valid = 1'b0;
      end
    end
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (tr_sig[c] !== exp_sig(1'b1, (c > 4) ? c - 4 : c)) begin
        n_errors++;
        $display("FAIL b2b_sig cyc %0d got %b exp %b", c, tr_sig[c], exp_sig(1'b1, (c > 4) ? c - 4 : c));
      end
    end
    n_checks++;
    if (tr_wd[3] !== e1 || tr_wd[7] !== e2) begin
      n_errors++;
      $display("FAIL b2b_wdata got %h/%h exp %h/%h", tr_wd[3], tr_wd[7], e1, e2);
    end
    n_checks++;
    if (tr_addr[7] !== a2[12:3]) begin
      n_errors++;
      $display("FAIL b2b_addr got %h exp %h", tr_addr[7], a2[12:3]);
    end
  endtask

  task automatic test_reset_mid;
    int          wr_before;
    bit          is_ram;
    logic [12:0] a;
    a = 13'($urandom_range(0, 8191));
    issue_and_trace(2'd0, 1'b0, a, 1'b1, 2);
    n_checks++;
    if (dbg_state !== ST_MOD) begin
      n_errors++;
      $display("FAIL mid_in_mod got %0d exp %0d", dbg_state, ST_MOD);
    end
    wr_before = wr_cnt;
    #2 RST_n = 1'b0;
    #1;
    n_checks++;
    if ({RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready, RAM_Addr, RAM_WrData, WB_Register} !== {4'b0001, 26'd0}) begin
      n_errors++;
      $display("FAIL mid_reset_outputs got %b %h %h %h", {RAM_RdEn, RAM_WrEn, wb_if.WB_Done, wb_if.WB_Ready},
               RAM_Addr, RAM_WrData, WB_Register);
    end
    exp_reg = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    n_checks++;
    if (wr_cnt !== wr_before) begin
      n_errors++;
      $display("FAIL mid_reset_no_write got %0d exp %0d", wr_cnt, wr_before);
    end
    a = 13'($urandom_range(0, 8191));
    model_cmd(2'd1, 1'b0, a, 1'b1, is_ram);
    issue_and_trace(2'd1, 1'b0, a, 1'b1, 4);
    n_checks++;
    if (tr_sig[1] !== 4'b1000 || tr_sig[3] !== 4'b0110 || tr_wd[3] !== exp_q[0]) begin
      n_errors++;
      $display("FAIL mid_reset_next got %b/%b wd %h exp 1000/0110 wd %h", tr_sig[1], tr_sig[3], tr_wd[3], exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

`ifdef RLO_WB_FWD_EN
  task automatic test_fwd;
    bit is_ram;
    model_cmd(2'd1, 1'b0, 13'h40, 1'b1, is_ram);
    void'(exp_q.pop_front());
    issue_and_trace(2'd1, 1'b0, 13'h40, 1'b1, 4);
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if ({tr_fv[c], tr_fa[c], tr_fb[c]} !== ((c <= 3) ? {1'b1, 13'h40, 1'b1} : 15'd0)) begin
        n_errors++;
        $display("FAIL fwd cyc %0d got %b %h %b", c, tr_fv[c], tr_fa[c], tr_fb[c]);
      end
    end
  endtask
`endif

  task automatic test_random;
    bit          is_ram;
    logic [1:0]  op;
    logic        dest, rlo;
    logic [12:0] a;
    logic [7:0]  e;
    for (int n = 0; n < 80; n++) begin
      op   = 2'($urandom_range(0, 3));
      dest = 1'($urandom_range(0, 1));
      rlo  = 1'($urandom_range(0, 1));
      // Bias addresses into a small window so bytes get revisited.
      a    = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 63)) : 13'($urandom_range(0, 8191));
      model_cmd(op, dest, a, rlo, is_ram);
      issue_and_trace(op, dest, a, rlo, 5);
      for (int c = 1; c <= 5; c++) begin
        n_checks++;
        if (tr_sig[c] !== exp_sig(is_ram, c)) begin
          n_errors++;
          $display("FAIL rand_sig n %0d cyc %0d got %b exp %b", n, c, tr_sig[c], exp_sig(is_ram, c));
        end
`ifdef RLO_WB_FWD_EN
        n_checks++;
        if (tr_fv[c] !== (is_ram && (c <= 3))) begin
          n_errors++;
          $display("FAIL rand_fwd n %0d cyc %0d got %b", n, c, tr_fv[c]);
        end
`endif
      end
      n_checks++;
      if (tr_reg[1] !== exp_reg) begin
        n_errors++;
        $display("FAIL rand_reg n %0d got %h exp %h", n, tr_reg[1], exp_reg);
      end
      if (is_ram) begin
        e = exp_q.pop_front();
        n_checks++;
        if (tr_wd[3] !== e || tr_addr[3] !== a[12:3]) begin
          n_errors++;
          $display("FAIL rand_write n %0d got %h@%h exp %h@%h", n, tr_wd[3], tr_addr[3], e, a[12:3]);
        end
      end
    end
  endtask

  task automatic final_report;
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_ram[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL ram_image got %0d bad bytes exp 0", bad);
    end
    n_checks++;
    if (wr_cnt !== exp_wr_cnt || both_cnt !== 0) begin
      n_errors++;
      $display("FAIL write_count got %0d (overlap %0d) exp %0d (overlap 0)", wr_cnt, both_cnt, exp_wr_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    wr_cnt     = 0;
    both_cnt   = 0;
    exp_wr_cnt = 0;
    exp_reg    = 8'h00;
    poke_en    = 1'b0;
    poke_addr  = '0;
    poke_data  = '0;
    RST_n      = 1'b0;
    wb_if.WB_Valid = 1'b0;
    drive_cmd(2'd3, 1'b0, 13'd0, 1'b0);
    for (int i = 0; i < 1024; i++) poke(i, 8'($urandom_range(0, 255)));
    test_reset();
    test_assign_ram();
    test_reset_op_ram();
    test_noop();
    test_reg_dest();
    test_back_to_back();
    test_reset_mid();
`ifdef RLO_WB_FWD_EN
    test_fwd();
`endif
    test_random();
    repeat (2) @(posedge CLK);
    final_report();
    $finish;
  end

endmodule
